// File: rtl/status_register_unit.sv
// status_register_unit: EX-stage NZCV status register with same-cycle
// forwarding to ID, a one-level save/restore shadow, a change pulse and a
// saturating count of accepted flag writes. Bit order: [3]=N [2]=Z [1]=C [0]=V.
module status_register_unit #(
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               ex_valid,
  input  logic               ex_s_bit,
  input  logic               ex_kill,
  input  logic [3:0]         ex_flags,
  input  logic               save_req,
  input  logic               restore_req,
  input  logic               clear_count,
  output logic [3:0]         status_out,
  output logic [3:0]         sr_q,
  output logic [3:0]         saved_q,
  output logic               sr_changed,
  output logic [COUNT_W-1:0] update_count
);

  logic       we;
  logic [3:0] sr_next;

  // Accepted EX flag write: live, flag-setting, not squashed, not stalled.
  always_comb begin
    we = ex_valid & ex_s_bit & ~ex_kill & ~freeze;
  end

  // Next SR value: restore beats an EX write, otherwise hold.
  always_comb begin
    sr_next = sr_q;
    if (restore_req) begin
      sr_next = saved_q;
    end else if (we) begin
      sr_next = ex_flags;
    end
  end

  // Status word for ID. Flags are forwarded only when they will actually be
  // written, so a write overridden by a same-cycle restore is not bypassed;
  // the restored value reaches ID a cycle later through sr_q.
  always_comb begin
    status_out = sr_q;
    if (rst) begin
      status_out = '0;
    end else if ((BYPASS != 0) && we && !restore_req) begin
      status_out = ex_flags;
    end
  end

  // Architectural SR and the one-cycle change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      sr_changed <= 1'b0;
    end else begin
      sr_q       <= sr_next;
      sr_changed <= (sr_next != sr_q);
    end
  end

  // Shadow register: plain save captures a same-cycle write; save together
  // with restore swaps using the pre-edge SR.
  always_ff @(posedge clk) begin
    if (rst) begin
      saved_q <= '0;
    end else if (save_req) begin
      if (restore_req) begin
        saved_q <= sr_q;
      end else begin
        saved_q <= we ? ex_flags : sr_q;
      end
    end
  end

  // Saturating count of writes that reached the SR; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_count <= '0;
    end else if (clear_count) begin
      update_count <= '0;
    end else if (we && !restore_req && (update_count != '1)) begin
      update_count <= update_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_status_register_unit.sv
// Directed bench for status_register_unit: one forwarding instance with a wide
// counter and one registered-only instance with a 2-bit counter, fed the same
// stimulus and checked against hand-computed values.
module tb_status_register_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic       ex_valid;
  logic       ex_s_bit;
  logic       ex_kill;
  logic [3:0] ex_flags;
  logic       save_req;
  logic       restore_req;
  logic       clear_count;

  logic [3:0] status_a, sr_a, saved_a;
  logic       chg_a;
  logic [7:0] cnt_a;
  logic [3:0] status_b, sr_b, saved_b;
  logic       chg_b;
  logic [1:0] cnt_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  status_register_unit #(.BYPASS(1), .COUNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .ex_valid(ex_valid),
    .ex_s_bit(ex_s_bit), .ex_kill(ex_kill), .ex_flags(ex_flags),
    .save_req(save_req), .restore_req(restore_req), .clear_count(clear_count),
    .status_out(status_a), .sr_q(sr_a), .saved_q(saved_a),
    .sr_changed(chg_a), .update_count(cnt_a)
  );

  status_register_unit #(.BYPASS(0), .COUNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .ex_valid(ex_valid),
    .ex_s_bit(ex_s_bit), .ex_kill(ex_kill), .ex_flags(ex_flags),
    .save_req(save_req), .restore_req(restore_req), .clear_count(clear_count),
    .status_out(status_b), .sr_q(sr_b), .saved_q(saved_b),
    .sr_changed(chg_b), .update_count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic k, input logic f,
                       input logic [3:0] fl, input logic sv, input logic rs, input logic cl);
    ex_valid    = v;
    ex_s_bit    = s;
    ex_kill     = k;
    freeze      = f;
    ex_flags    = fl;
    save_req    = sv;
    restore_req = rs;
    clear_count = cl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one edge; outputs are then sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain accepted write of one flag value, then inputs return to idle.
  task automatic write_flags(input logic [3:0] fl);
    drive(1'b1, 1'b1, 1'b0, 1'b0, fl, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    #1;
    check_eq("rst_status_a", 16'(status_a), 16'h0);
    check_eq("rst_status_b", 16'(status_b), 16'h0);
    check_eq("rst_sr", 16'(sr_a), 16'h0);
    check_eq("rst_saved", 16'(saved_a), 16'h0);
    check_eq("rst_count", 16'(cnt_a), 16'h0);
    check_eq("rst_changed", 16'(chg_a), 16'h0);

    // Basic write with same-cycle forwarding.
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("wr_bypass_a", 16'(status_a), 16'h4);
    check_eq("wr_nobypass_b", 16'(status_b), 16'h0);
    tick();
    idle();
    #1;
    check_eq("wr_sr", 16'(sr_a), 16'h4);
    check_eq("wr_changed", 16'(chg_a), 16'h1);
    check_eq("wr_count", 16'(cnt_a), 16'h1);
    check_eq("wr_status_b", 16'(status_b), 16'h4);

    // Killed instruction: no forward, no write, no count.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("kill_status", 16'(status_a), 16'h4);
    tick();
    check_eq("kill_sr", 16'(sr_a), 16'h4);
    check_eq("kill_changed", 16'(chg_a), 16'h0);
    check_eq("kill_count", 16'(cnt_a), 16'h1);

    // Frozen instruction, then freeze drops with inputs held.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("frz_status", 16'(status_a), 16'h4);
    tick();
    check_eq("frz_sr", 16'(sr_a), 16'h4);
    check_eq("frz_count", 16'(cnt_a), 16'h1);
    freeze = 1'b0;
    #1;
    check_eq("unfrz_status", 16'(status_a), 16'h9);
    tick();
    idle();
    #1;
    check_eq("unfrz_sr", 16'(sr_a), 16'h9);
    check_eq("unfrz_count", 16'(cnt_a), 16'h2);
    check_eq("unfrz_changed", 16'(chg_a), 16'h1);

    // Save captures a same-cycle write.
    write_flags(4'b0010);
    check_eq("pre_save_sr", 16'(sr_a), 16'h2);
    check_eq("cnt_b_sat", 16'(cnt_b), 16'h3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check_eq("save_saved", 16'(saved_a), 16'hC);
    check_eq("save_sr", 16'(sr_a), 16'hC);
    check_eq("save_count", 16'(cnt_a), 16'h4);

    // Build saved=0011, sr=1000; then restore overrides a write.
    write_flags(4'b0011);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check_eq("save2_saved", 16'(saved_a), 16'h3);
    write_flags(4'b1000);
    check_eq("pre_rest_count", 16'(cnt_a), 16'h6);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("rest_status", 16'(status_a), 16'h8);
    tick();
    idle();
    #1;
    check_eq("rest_sr", 16'(sr_a), 16'h3);
    check_eq("rest_count", 16'(cnt_a), 16'h6);
    check_eq("rest_saved", 16'(saved_a), 16'h3);
    check_eq("rest_changed", 16'(chg_a), 16'h1);
    check_eq("rest_status_b", 16'(status_b), 16'h3);

    // Swap: save+restore together, EX write ignored.
    write_flags(4'b0110);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check_eq("swap_sr", 16'(sr_a), 16'h3);
    check_eq("swap_saved", 16'(saved_a), 16'h6);
    check_eq("swap_count", 16'(cnt_a), 16'h7);

    // Clear wins over a same-cycle increment; the write itself still lands.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check_eq("clr_count_a", 16'(cnt_a), 16'h0);
    check_eq("clr_count_b", 16'(cnt_b), 16'h0);
    check_eq("clr_sr", 16'(sr_a), 16'hA);

    // Five writes, repeated value: counter a counts, b saturates at 3;
    // only the first write changes the SR.
    for (int unsigned i = 0; i < 5; i++) begin
      write_flags(4'b0001);
      check_eq("rep_changed", 16'(chg_a), (i == 0) ? 16'h1 : 16'h0);
    end
    check_eq("rep_count_a", 16'(cnt_a), 16'h5);
    check_eq("rep_count_b", 16'(cnt_b), 16'h3);

    // Reset overrides a same-cycle write and save.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("mrst_status_a", 16'(status_a), 16'h0);
    check_eq("mrst_status_b", 16'(status_b), 16'h0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_eq("mrst_sr", 16'(sr_a), 16'h0);
    check_eq("mrst_saved", 16'(saved_a), 16'h0);
    check_eq("mrst_count", 16'(cnt_a), 16'h0);
    check_eq("mrst_changed", 16'(chg_a), 16'h0);
    check_eq("mrst_status", 16'(status_a), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
